// File: rtl/tilemap_pixel_shifter_if.sv
// Shared bus between the tilemap generator/fetch side and the pixel shifter.
interface tilemap_pixel_shifter_if;
   logic        i_EMU_CLK6MPCEN_n;
   logic        i_ABS_4H;
   logic        i_ABS_2H;
   logic        i_ABS_1H;
   logic        i_HFLIP;
   logic [7:0]  i_TILEATTR;
   logic [31:0] i_CHARDATA;
   logic        i_SHIFTA1;
   logic        i_SHIFTA2;
   logic        i_SHIFTB;
   logic [3:0]  o_TMA_PIXEL;
   logic [3:0]  o_TMB_PIXEL;
   logic [6:0]  o_TMA_COLOR;
   logic [6:0]  o_TMB_COLOR;
   logic        o_TMA_OPAQUE;
   logic        o_TMB_OPAQUE;

   modport master (
      output i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H, i_HFLIP, i_TILEATTR,
             i_CHARDATA, i_SHIFTA1, i_SHIFTA2, i_SHIFTB,
      input  o_TMA_PIXEL, o_TMB_PIXEL, o_TMA_COLOR, o_TMB_COLOR, o_TMA_OPAQUE, o_TMB_OPAQUE
   );

   modport slave (
      input  i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H, i_HFLIP, i_TILEATTR,
             i_CHARDATA, i_SHIFTA1, i_SHIFTA2, i_SHIFTB,
      output o_TMA_PIXEL, o_TMB_PIXEL, o_TMA_COLOR, o_TMB_COLOR, o_TMA_OPAQUE, o_TMB_OPAQUE
   );
endinterface

// File: rtl/tilemap_pixel_shifter.sv
// Captures tile attribute/line data for layers A and B at fixed pixel phases and shifts
// pixels out head-first on each pixel clock enable; strobes reload the shifters.
module tilemap_pixel_shifter (
   input  logic                   i_EMU_MCLK,
   input  logic                   i_EMU_RST,
   tilemap_pixel_shifter_if.slave bus_io
);
   logic        ce;
   logic [2:0]  phase;
   logic [7:0]  attr_a_q, attr_a_d, attr_b_q, attr_b_d;
   logic [31:0] char_a_q, char_a_d, char_b_q, char_b_d;
   logic [31:0] stg_data_q, stg_data_d;
   logic [6:0]  stg_pal_q, stg_pal_d;
   logic [31:0] sr_a_q, sr_a_d, sr_b_q, sr_b_d;
   logic [6:0]  col_a_q, col_a_d, col_b_q, col_b_d;

   function automatic logic [31:0] nibble_reverse(input logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[4*i +: 4] = d[4*(7-i) +: 4];
      return r;
   endfunction

   assign ce    = ~bus_io.i_EMU_CLK6MPCEN_n;
   assign phase = {bus_io.i_ABS_4H, bus_io.i_ABS_2H, bus_io.i_ABS_1H};

   always_comb begin
      attr_a_d   = attr_a_q;
      attr_b_d   = attr_b_q;
      char_a_d   = char_a_q;
      char_b_d   = char_b_q;
      stg_data_d = stg_data_q;
      stg_pal_d  = stg_pal_q;
      sr_a_d     = sr_a_q;
      sr_b_d     = sr_b_q;
      col_a_d    = col_a_q;
      col_b_d    = col_b_q;
      if (ce) begin
         // Strobes read pre-edge latch contents, so a same-edge capture never leaks through.
         sr_a_d = {sr_a_q[27:0], 4'h0};
         if (!bus_io.i_SHIFTA1) begin
            sr_a_d  = stg_data_q;
            col_a_d = stg_pal_q;
         end
         if (!bus_io.i_SHIFTA2) begin
            stg_data_d = char_a_q;
            stg_pal_d  = attr_a_q[6:0];
         end
         sr_b_d = {sr_b_q[27:0], 4'h0};
         if (!bus_io.i_SHIFTB) begin
            sr_b_d  = char_b_q;
            col_b_d = attr_b_q[6:0];
         end
         // Flip is resolved once at char capture so the shifter always runs head-first.
         case (phase)
            3'd3: attr_a_d = bus_io.i_TILEATTR;
            3'd5: char_a_d = (attr_a_q[7] ^ bus_io.i_HFLIP) ? nibble_reverse(bus_io.i_CHARDATA)
                                                           : bus_io.i_CHARDATA;
            3'd7: attr_b_d = bus_io.i_TILEATTR;
            3'd1: char_b_d = (attr_b_q[7] ^ bus_io.i_HFLIP) ? nibble_reverse(bus_io.i_CHARDATA)
                                                           : bus_io.i_CHARDATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
      if (i_EMU_RST) begin
         attr_a_q   <= '0;
         attr_b_q   <= '0;
         char_a_q   <= '0;
         char_b_q   <= '0;
         stg_data_q <= '0;
         stg_pal_q  <= '0;
         sr_a_q     <= '0;
         sr_b_q     <= '0;
         col_a_q    <= '0;
         col_b_q    <= '0;
      end else begin
         attr_a_q   <= attr_a_d;
         attr_b_q   <= attr_b_d;
         char_a_q   <= char_a_d;
         char_b_q   <= char_b_d;
         stg_data_q <= stg_data_d;
         stg_pal_q  <= stg_pal_d;
         sr_a_q     <= sr_a_d;
         sr_b_q     <= sr_b_d;
         col_a_q    <= col_a_d;
         col_b_q    <= col_b_d;
      end
   end

   assign bus_io.o_TMA_PIXEL  = sr_a_q[31:28];
   assign bus_io.o_TMB_PIXEL  = sr_b_q[31:28];
   assign bus_io.o_TMA_COLOR  = col_a_q;
   assign bus_io.o_TMB_COLOR  = col_b_q;
   assign bus_io.o_TMA_OPAQUE = |sr_a_q[31:28];
   assign bus_io.o_TMB_OPAQUE = |sr_b_q[31:28];
endmodule

// File: tb/tb_tilemap_pixel_shifter.sv
// Self-checking bench: directed scenarios plus a randomized stream against a tile-level model.
module tb_tilemap_pixel_shifter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tilemap_pixel_shifter_if ifc ();

   tilemap_pixel_shifter dut (
      .i_EMU_MCLK (clk),
      .i_EMU_RST  (rst),
      .bus_io     (ifc)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [2:0]  ph = 3'd0;

   logic [11:0] got_a, got_b;
   assign got_a = {ifc.o_TMA_PIXEL, ifc.o_TMA_COLOR, ifc.o_TMA_OPAQUE};
   assign got_b = {ifc.o_TMB_PIXEL, ifc.o_TMB_COLOR, ifc.o_TMB_OPAQUE};

   // Tile-level model: each tile is a list of 8 pixels in display order plus a palette;
   // the displayed tile is indexed by how many CEs have passed since its reload.
   logic [7:0] m_fa_attr, m_fb_attr;
   logic [3:0] m_fa_pix [8];
   logic [3:0] m_fb_pix [8];
   logic [3:0] m_sa_pix [8];
   logic [3:0] m_ca_pix [8];
   logic [3:0] m_cb_pix [8];
   logic [6:0] m_sa_pal, m_ca_pal, m_cb_pal;
   int         m_ia, m_ib;

   function automatic logic [3:0] tile_pix(logic [31:0] ch, logic flip, int k);
      logic [31:0] t;
      t = ch >> (flip ? 4 * k : 4 * (7 - k));
      return t[3:0];
   endfunction

   function automatic logic [11:0] trip(logic [3:0] p, logic [6:0] c);
      return {p, c, p != 4'h0};
   endfunction

   function automatic logic [11:0] exp_a();
      return trip((m_ia < 8) ? m_ca_pix[m_ia] : 4'h0, m_ca_pal);
   endfunction

   function automatic logic [11:0] exp_b();
      return trip((m_ib < 8) ? m_cb_pix[m_ib] : 4'h0, m_cb_pal);
   endfunction

   task automatic model_reset();
      m_fa_attr = '0; m_fb_attr = '0;
      m_sa_pal = '0; m_ca_pal = '0; m_cb_pal = '0;
      m_ia = 8; m_ib = 8;
      for (int k = 0; k < 8; k++) begin
         m_fa_pix[k] = '0; m_fb_pix[k] = '0; m_sa_pix[k] = '0;
         m_ca_pix[k] = '0; m_cb_pix[k] = '0;
      end
   endtask

   task automatic model_ce(input logic [2:0] p, input logic [7:0] attr, input logic [31:0] ch,
                           input logic hf, input logic a1n, input logic a2n, input logic bn);
      if (!a1n) begin m_ca_pix = m_sa_pix; m_ca_pal = m_sa_pal; m_ia = 0; end
      else if (m_ia < 8) m_ia++;
      if (!a2n) begin m_sa_pix = m_fa_pix; m_sa_pal = m_fa_attr[6:0]; end
      if (!bn) begin m_cb_pix = m_fb_pix; m_cb_pal = m_fb_attr[6:0]; m_ib = 0; end
      else if (m_ib < 8) m_ib++;
      if (p == 3'd3) m_fa_attr = attr;
      if (p == 3'd7) m_fb_attr = attr;
      if (p == 3'd5) for (int k = 0; k < 8; k++) m_fa_pix[k] = tile_pix(ch, m_fa_attr[7] ^ hf, k);
      if (p == 3'd1) for (int k = 0; k < 8; k++) m_fb_pix[k] = tile_pix(ch, m_fb_attr[7] ^ hf, k);
   endtask

   task automatic ce_step(input logic [7:0] attr, input logic [31:0] ch, input logic hf,
                          input logic a1n, input logic a2n, input logic bn);
      ifc.i_EMU_CLK6MPCEN_n = 1'b0;
      {ifc.i_ABS_4H, ifc.i_ABS_2H, ifc.i_ABS_1H} = ph;
      ifc.i_TILEATTR = attr;
      ifc.i_CHARDATA = ch;
      ifc.i_HFLIP    = hf;
      ifc.i_SHIFTA1  = a1n;
      ifc.i_SHIFTA2  = a2n;
      ifc.i_SHIFTB   = bn;
      model_ce(ph, attr, ch, hf, a1n, a2n, bn);
      @(posedge clk); #1;
      ph = ph + 3'd1;
   endtask

   task automatic idle_step();
      ce_step(8'($urandom), $urandom, 1'($urandom), 1'b1, 1'b1, 1'b1);
   endtask

   task automatic idle_to(input logic [2:0] p);
      while (ph != p) idle_step();
   endtask

   task automatic gap(input int n);
      ifc.i_EMU_CLK6MPCEN_n = 1'b1;
      repeat (n) begin
         {ifc.i_ABS_4H, ifc.i_ABS_2H, ifc.i_ABS_1H} = 3'($urandom);
         ifc.i_TILEATTR = 8'($urandom);
         ifc.i_CHARDATA = $urandom;
         ifc.i_HFLIP    = 1'($urandom);
         ifc.i_SHIFTA1  = 1'($urandom);
         ifc.i_SHIFTA2  = 1'($urandom);
         ifc.i_SHIFTB   = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic load_b(input logic [7:0] attr, input logic [31:0] ch, input logic hf);
      idle_to(3'd7);
      ce_step(attr, $urandom, 1'($urandom), 1'b1, 1'b1, 1'b1);
      idle_step();
      ce_step(8'($urandom), ch, hf, 1'b1, 1'b1, 1'b1);
      idle_step();
      ce_step(8'($urandom), $urandom, 1'($urandom), 1'b1, 1'b1, 1'b0);
   endtask

   task automatic load_a_stage(input logic [7:0] attr, input logic [31:0] ch, input logic hf);
      idle_to(3'd3);
      ce_step(attr, $urandom, 1'($urandom), 1'b1, 1'b1, 1'b1);
      idle_step();
      ce_step(8'($urandom), ch, hf, 1'b1, 1'b1, 1'b1);
      repeat (5) idle_step();
      ce_step(8'($urandom), $urandom, 1'($urandom), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      #2;
      if (got_a !== 12'h0) begin n_bad++; $display("FAIL reset_a got %h want 000", got_a); end
      n_cmp++;
      if (got_b !== 12'h0) begin n_bad++; $display("FAIL reset_b got %h want 000", got_b); end
      n_cmp++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      load_a_stage(8'h41, 32'h1111_1111, 1'b0);
      load_b(8'h22, 32'h7777_7777, 1'b0);
      if (got_b !== trip(4'h7, 7'h22)) begin
         n_bad++; $display("FAIL pre_reset_b got %h want %h", got_b, trip(4'h7, 7'h22));
      end
      n_cmp++;
      rst = 1'b1;
      #2;
      if (got_b !== 12'h0) begin n_bad++; $display("FAIL async_reset_b got %h want 000", got_b); end
      n_cmp++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      // Strobes right after release must only move cleared latches/staging.
      ce_step(8'($urandom), $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
      if (got_a !== 12'h0) begin n_bad++; $display("FAIL post_reset_a got %h want 000", got_a); end
      n_cmp++;
      if (got_b !== 12'h0) begin n_bad++; $display("FAIL post_reset_b got %h want 000", got_b); end
      n_cmp++;
   endtask

   task automatic test_a_pipeline();
      load_a_stage(8'h2A, 32'hF0F0_F0F0, 1'b0);
      repeat (3) idle_step();
      if (got_a !== 12'h0) begin n_bad++; $display("FAIL a_before_shifta1 got %h want 000", got_a); end
      n_cmp++;
      ce_step(8'($urandom), $urandom, 1'($urandom), 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         if (got_a !== trip((k % 2 == 0) ? 4'hF : 4'h0, 7'h2A)) begin
            n_bad++;
            $display("FAIL a_pipeline k=%0d got %h want %h", k, got_a,
                     trip((k % 2 == 0) ? 4'hF : 4'h0, 7'h2A));
         end
         n_cmp++;
         idle_step();
      end
   endtask

   task automatic test_b_order(input logic [7:0] attr, input logic hf, input logic rev);
      load_b(attr, 32'h1234_5678, hf);
      for (int k = 0; k < 8; k++) begin
         if (got_b !== trip(rev ? 4'(8 - k) : 4'(k + 1), 7'h15)) begin
            n_bad++;
            $display("FAIL b_order attr=%h hf=%0d k=%0d got %h want %h", attr, hf, k, got_b,
                     trip(rev ? 4'(8 - k) : 4'(k + 1), 7'h15));
         end
         n_cmp++;
         idle_step();
      end
   endtask

   task automatic test_drain();
      load_b(8'h4C, 32'h9999_999A, 1'b0);
      for (int k = 0; k < 12; k++) begin
         if (got_b !== trip((k < 7) ? 4'h9 : (k == 7) ? 4'hA : 4'h0, 7'h4C)) begin
            n_bad++;
            $display("FAIL drain k=%0d got %h want %h", k, got_b,
                     trip((k < 7) ? 4'h9 : (k == 7) ? 4'hA : 4'h0, 7'h4C));
         end
         n_cmp++;
         idle_step();
      end
   endtask

   task automatic test_ce_gating();
      load_b(8'h33, 32'h1234_5678, 1'b0);
      idle_step();
      idle_step();
      gap(5);
      for (int k = 2; k < 8; k++) begin
         if (got_b !== trip(4'(k + 1), 7'h33)) begin
            n_bad++; $display("FAIL ce_gating k=%0d got %h want %h", k, got_b, trip(4'(k + 1), 7'h33));
         end
         n_cmp++;
         if (got_a !== exp_a()) begin
            n_bad++; $display("FAIL ce_gating_a k=%0d got %h want %h", k, got_a, exp_a());
         end
         n_cmp++;
         idle_step();
      end
   endtask

   task automatic test_random_stream();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 15) == 0) gap($urandom_range(1, 5));
         ce_step(8'($urandom), $urandom, 1'($urandom), $urandom_range(0, 5) != 0,
                 $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
         if (got_a !== exp_a()) begin
            n_bad++; $display("FAIL rand_a n=%0d got %h want %h", n, got_a, exp_a());
         end
         n_cmp++;
         if (got_b !== exp_b()) begin
            n_bad++; $display("FAIL rand_b n=%0d got %h want %h", n, got_b, exp_b());
         end
         n_cmp++;
      end
   endtask

   initial begin
      ifc.i_EMU_CLK6MPCEN_n = 1'b1;
      {ifc.i_ABS_4H, ifc.i_ABS_2H, ifc.i_ABS_1H} = 3'd0;
      ifc.i_HFLIP    = 1'b0;
      ifc.i_TILEATTR = '0;
      ifc.i_CHARDATA = '0;
      ifc.i_SHIFTA1  = 1'b1;
      ifc.i_SHIFTA2  = 1'b1;
      ifc.i_SHIFTB   = 1'b1;
      model_reset();
      test_reset();
      test_a_pipeline();
      test_b_order(8'h15, 1'b0, 1'b0);
      test_b_order(8'h95, 1'b0, 1'b1);
      test_b_order(8'h95, 1'b1, 1'b0);
      test_drain();
      test_ce_gating();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tilemap_pixel_shifter.md
# tilemap_pixel_shifter

Downstream stage of the tilemap generator: captures per-tile attribute and CHARRAM line data for tilemaps A and B from the shared fetch buses at fixed pixel phases. Reloads a per-layer 32-bit pixel shift register on the generator's active-low SHIFTA1/SHIFTA2/SHIFTB strobes, which realizes fine horizontal scroll. Emits one 4-bit pixel plus 7-bit palette per layer per 6 MHz pixel toward the priority/colour mixer.

## Interface
Parameters: none.

Ports:
- i_EMU_MCLK  in  1  master clock; all state on rising edge
- i_EMU_RST  in  1  asynchronous, active-high reset
- i_EMU_CLK6MPCEN_n  in  1  pixel clock enable, active low; no state changes while high
- i_ABS_4H, i_ABS_2H, i_ABS_1H  in  1 each  pixel phase within 8-pixel slot
- i_HFLIP  in  1  global horizontal flip
- i_TILEATTR  in  8  VRAM attribute bus; [6:0] palette, [7] tile X-flip
- i_CHARDATA  in  32  CHARRAM tile-line data, 8 pixels x 4 bpp, pixel 0 in [31:28]
- i_SHIFTA1  in  1  active low; staging A -> shift register A
- i_SHIFTA2  in  1  active low; fetch latch A -> staging A
- i_SHIFTB  in  1  active low; fetch latch B -> shift register B
- o_TMA_PIXEL, o_TMB_PIXEL  out  4 each  current pixel index; 0 = transparent
- o_TMA_COLOR, o_TMB_COLOR  out  7 each  palette of the tile the current pixel belongs to
- o_TMA_OPAQUE, o_TMB_OPAQUE  out  1 each  pixel != 0

## Operation
- Phase P = {4H,2H,1H}, sampled on each enabled edge (CE = !i_EMU_CLK6MPCEN_n).
- Fetch capture on CE:
  - P=3: A attribute latch <= i_TILEATTR.
  - P=5: A char latch <= i_CHARDATA.
  - P=7: B attribute latch <= i_TILEATTR.
  - P=1: B char latch <= i_CHARDATA.
- Flip resolve at capture: effective flip = attr[7] ^ i_HFLIP, using i_HFLIP at char-capture time. If set, nibble order is reversed on storing (pixel 7 becomes head). Shift direction is always head-first.
- Layer A, two-stage, on CE:
  - SHIFTA2 low: staging A (data+palette) <= fetch latch A.
  - SHIFTA1 low: SR_A <= staging A value before this edge, COL_A <= staging palette.
  - Otherwise: SR_A <= SR_A << 4, zero fill.
- Layer B, single stage, on CE:
  - SHIFTB low: SR_B <= fetch latch B, COL_B <= B palette.
  - Otherwise shift as for A.
- Simultaneous capture and strobe on the same edge: the strobe transfers the pre-edge latch contents (non-blocking semantics). The same rule applies to SHIFTA1 and SHIFTA2 both low.
- Strobe held low over multiple CEs: reloads every CE, so the head pixel repeats.
- No reload for more than 8 CEs: SR drains to 0, giving transparent output. Palette holds.
- Outputs are direct register taps: PIXEL = SR[31:28], COLOR = COL, OPAQUE = |SR[31:28].
- Reset clears every latch, staging, SR and COL to 0; all outputs read 0. Reset mid-line discards any in-flight tile. Capture resumes at the next matching phase after release.

## Timing
- Latency: pixel visible the MCLK edge after the reload CE, valid for one full pixel period (until next CE).
- A path: char capture at P=5 -> SHIFTA2 -> SHIFTA1. Minimum 2 CEs from staging to output.
- B path: char capture at P=1 -> SHIFTB. One CE from latch to output.
- Fine scroll s (0..7) shifts reload point by s pixels. Shifter makes no phase assumption beyond strobes.
- CE gaps between MCLK edges: state frozen, outputs stable.

## Test plan
- Reset: assert i_EMU_RST mid-stream -> all outputs 0 asynchronously; after release, first opaque pixel only after a full capture+strobe sequence.
- B basic: TILEATTR=0x15 at P=7, CHARDATA=0x12345678 at P=1, SHIFTB low at next P=3 -> o_TMB_PIXEL 1,2,...,8 on 8 consecutive CEs, COLOR=0x15, OPAQUE high throughout.
- Flip: same as previous with attr bit7=1, HFLIP=0 -> 8,7,...,1; with HFLIP=1 too -> 1..8 order.
- A pipeline: CHARDATA=0xF0F0F0F0 at P=5, SHIFTA2 low at P=3, SHIFTA1 low at P=7 -> pixels F,0,F,0... with OPAQUE toggling, starting edge after SHIFTA1 CE.
- Drain: one SHIFTB load of 0x9999999A, no further strobes -> 9x7, A, then 0 with OPAQUE low, COLOR unchanged.
- CE gating: hold i_EMU_CLK6MPCEN_n high 5 MCLKs mid-tile -> outputs and state unchanged; sequence resumes exactly.
